seg_scroll_mux: RTL and testbench

Display back-end for the digit sequencer: captures each 4-bit digit code the sequencer emits on a load strobe, keeps the most recent DIGITS codes in a scrolling buffer, and time-multiplexes them onto a common-anode 7-segment display. It sits directly downstream of the sequencer's 4-bit digit output and drives board pins.

---
 rtl/seg_scroll_mux.sv | 107 ++++++++++
 tb/tb_seg_scroll_mux.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scroll_mux.sv
`default_nettype none
// ============================================================================
// Module   : seg_scroll_mux
// Brief    : Scrolling digit buffer time-multiplexed onto a common-anode
//            7-segment display. SEG_HEX_DECODE_EN enables A-F glyphs.
// Revision : 1.0 - initial release
// ============================================================================
module seg_scroll_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        digit_in,
  input  logic              load,
  input  logic              clr,
  output logic [DIGITS-1:0] an,
  output logic [6:0]        seg
);

  localparam int              c_IW        = $clog2(DIGITS);
  localparam int              c_RW        = $clog2(REFRESH_DIV);
  localparam logic [6:0]      c_BLANK     = 7'b1111111;
  localparam logic [c_RW-1:0] c_RCNT_MAX  = c_RW'(REFRESH_DIV - 1);
  localparam logic [c_IW-1:0] c_IDX_MAX   = c_IW'(DIGITS - 1);

  logic [c_RW-1:0]   r_rcnt;
  logic [c_IW-1:0]   r_idx;
  logic [DIGITS-1:0] r_valid;
  logic [3:0]        r_code [DIGITS];

  logic [DIGITS-1:0] w_an_next;
  logic [6:0]        w_seg_next;

  // Segment order is {g,f,e,d,c,b,a}, active-low; invalid slots render blank.
  function automatic logic [6:0] f_decode(input logic valid, input logic [3:0] code);
    logic [6:0] v;
    v = c_BLANK;
    if (valid) begin
      case (code)
        4'd0:  v = 7'b1000000;
        4'd1:  v = 7'b1111001;
        4'd2:  v = 7'b0100100;
        4'd3:  v = 7'b0110000;
        4'd4:  v = 7'b0011001;
        4'd5:  v = 7'b0010010;
        4'd6:  v = 7'b0000010;
        4'd7:  v = 7'b1111000;
        4'd8:  v = 7'b0000000;
        4'd9:  v = 7'b0010000;
`ifdef SEG_HEX_DECODE_EN
        4'd10: v = 7'b0001000;
        4'd11: v = 7'b0000011;
        4'd12: v = 7'b1000110;
        4'd13: v = 7'b0100001;
        4'd14: v = 7'b0000110;
        4'd15: v = 7'b0001110;
`else
        4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: v = c_BLANK;
`endif
        default: v = c_BLANK;
      endcase
    end
    return v;
  endfunction

  always_comb begin
    w_an_next = '1;
    for (int k = 0; k < DIGITS; k++) begin
      if (r_idx == c_IW'(k)) w_an_next[k] = 1'b0;
    end
  end

  assign w_seg_next = f_decode(r_valid[r_idx], r_code[r_idx]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rcnt  <= '0;
      r_idx   <= '0;
      r_valid <= '0;
      for (int k = 0; k < DIGITS; k++) r_code[k] <= 4'd0;
      an      <= '1;
      seg     <= c_BLANK;
    end else begin
      // Outputs reflect idx/buffer from before this edge, giving one cycle of latency.
      an  <= w_an_next;
      seg <= w_seg_next;

      if (r_rcnt == c_RCNT_MAX) begin
        r_rcnt <= '0;
        r_idx  <= (r_idx == c_IDX_MAX) ? '0 : r_idx + 1'b1;
      end else begin
        r_rcnt <= r_rcnt + 1'b1;
      end

      if (clr) begin
        r_valid <= '0;
      end else if (load) begin
        r_valid <= {r_valid[DIGITS-2:0], 1'b1};
        for (int k = 1; k < DIGITS; k++) r_code[k] <= r_code[k-1];
        r_code[0] <= digit_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg_scroll_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scroll_mux
// Brief    : Directed scoreboard bench for seg_scroll_mux (DIGITS=4, REFRESH_DIV=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scroll_mux;

  localparam int         DIGITS      = 4;
  localparam int         REFRESH_DIV = 4;
  localparam logic [6:0] c_BLANK     = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] digit_in;
  logic       load;
  logic       clr;
  logic [3:0] an;
  logic [6:0] seg;

  seg_scroll_mux #(
    .DIGITS      (DIGITS),
    .REFRESH_DIV (REFRESH_DIV)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .digit_in (digit_in),
    .load     (load),
    .clr      (clr),
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;
  int   cnt    = 0;

  function automatic logic [6:0] dec(input int d);
    case (d)
      0:  return 7'b1000000;
      1:  return 7'b1111001;
      2:  return 7'b0100100;
      3:  return 7'b0110000;
      4:  return 7'b0011001;
      5:  return 7'b0010010;
      6:  return 7'b0000010;
      7:  return 7'b1111000;
      8:  return 7'b0000000;
      9:  return 7'b0010000;
`ifdef SEG_HEX_DECODE_EN
      12: return 7'b1000110;
`endif
      default: return c_BLANK;
    endcase
  endfunction

  function automatic logic [3:0] an_pos(input int p);
    logic [3:0] v;
    v    = 4'b1111;
    v[p] = 1'b0;
    return v;
  endfunction

  // Position lit after c edges since reset release.
  function automatic int pos(input int c);
    return ((c - 1) / REFRESH_DIV) % DIGITS;
  endfunction

  task automatic push(input string tag, input logic [3:0] a, input logic [6:0] s);
    exp_t e;
    e.tag = tag;
    e.an  = a;
    e.seg = s;
    sbq.push_back(e);
  endtask

  task automatic check_pop();
    exp_t e;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty: got an=%b seg=%b required an expected entry", an, seg);
    end else begin
      e = sbq.pop_front();
      assert (an === e.an && seg === e.seg) else begin
        errors++;
        $error("FAIL %s (cnt=%0d): got an=%b seg=%b required an=%b seg=%b",
               e.tag, cnt, an, seg, e.an, e.seg);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cnt++;
  endtask

  task automatic run_to(input int target);
    while (cnt < target) tick();
  endtask

  task automatic load_digit(input int d);
    load     = 1'b1;
    digit_in = 4'(d);
    tick();
    load     = 1'b0;
  endtask

  task automatic frame_blank(input string tag);
    for (int i = 0; i < DIGITS * REFRESH_DIV; i++) begin
      push(tag, an_pos(pos(cnt + 1)), c_BLANK);
      tick();
      check_pop();
    end
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; clr = 1'b0; digit_in = 4'd0;

    // Reset hold
    repeat (3) tick();
    push("reset_hold", 4'b1111, c_BLANK);
    check_pop();

    // Release: blank frame scanning 1110,1101,1011,0111
    rst = 1'b0;
    cnt = 0;
    frame_blank("reset_scan");

    // Scroll 2,1,5,5 while idx=0: one-cycle latency visible on position 0
    push("load_pre", an_pos(0), c_BLANK);   load_digit(2); check_pop();
    push("load_lat2", an_pos(0), dec(2));   load_digit(1); check_pop();
    push("load_lat1", an_pos(0), dec(1));   load_digit(5); check_pop();
    push("load_lat5", an_pos(0), dec(5));   load_digit(5); check_pop();
    push("scroll_p1", an_pos(1), dec(5));   run_to(24); check_pop();
    push("scroll_p2", an_pos(2), dec(1));   run_to(28); check_pop();
    push("scroll_p3", an_pos(3), dec(2));   run_to(32); check_pop();
    push("scroll_p0", an_pos(0), dec(5));   run_to(36); check_pop();

    // Overflow with duplicates: slots 3..0 become 0,7,9,4
    load_digit(0); load_digit(0); load_digit(7); load_digit(9); load_digit(4);
    push("ovf_p2", an_pos(2), dec(7));      run_to(44); check_pop();
    push("ovf_p3", an_pos(3), dec(0));      run_to(48); check_pop();
    push("ovf_p0", an_pos(0), dec(4));      run_to(52); check_pop();
    push("ovf_p1", an_pos(1), dec(9));      run_to(56); check_pop();

    // Load of 8 on the edge where idx wraps 3 -> 0
    run_to(63);
    push("wrap_old", an_pos(3), dec(0));    load_digit(8); check_pop();
    push("wrap_load", an_pos(0), dec(8));   tick(); check_pop();

    // clr and load together: load dropped, everything blank
    clr = 1'b1; load = 1'b1; digit_in = 4'd3;
    push("clr_prev", an_pos(0), dec(8));    tick(); check_pop();
    clr = 1'b0; load = 1'b0;
    frame_blank("clr_blank");

    // Code 12: glyph C with hex decode, blank otherwise
    push("hex_pre", an_pos(0), c_BLANK);    load_digit(12); check_pop();
    push("hex_12", an_pos(0), dec(12));     tick(); check_pop();

    // Fill buffer 1,2,3,4 then reset while idx=2, with a concurrent load
    load_digit(1); load_digit(2); load_digit(3); load_digit(4);
    push("full_p2", an_pos(2), dec(2));     run_to(90); check_pop();
    rst = 1'b1; load = 1'b1; digit_in = 4'd9;
    push("rst_mid", 4'b1111, c_BLANK);      tick(); check_pop();
    rst = 1'b0; load = 1'b0;
    cnt = 0;
    frame_blank("rst_restart");

    if (sbq.size() != 0) begin
      errors++;
      checks++;
      $error("FAIL scoreboard_leftover: got %0d entries required 0", sbq.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
